// File: rtl/fpu_shift_pkg.sv
// Shared types and encodings for the FP add/sub shifter sequencer.
package fpu_shift_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_ADD_WAIT = 3'd2,
        ST_NORM     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic DIR_LEFT    = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic SEL_OPERAND = 1'b0;
    localparam logic SEL_RESULT  = 1'b1;

endpackage

// File: rtl/shift_amount_sat.sv
// Narrows an exponent difference to the shifter amount width, saturating at all-ones
// so any difference at or beyond the significand width still shifts everything out.
module shift_amount_sat #(
    parameter int EW  = 8,
    parameter int EWR = 5
) (
    input  logic [EW-1:0]  diff,
    output logic [EWR-1:0] amount
);

    logic [EW-1:0] high_part;

    assign high_part = diff >> EWR;
    assign amount    = (|high_part) ? {EWR{1'b1}} : diff[EWR-1:0];

endmodule

// File: rtl/fpu_shift_sequencer.sv
// Time-shares one registered barrel shifter between operand alignment and result
// normalisation in the FP add/sub datapath.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i, shifter controls all 0
// ALIGN    | right-shift smaller operand by saturated exponent difference
// ADD_WAIT | shifter idle, waiting for the adder result
// NORM     | normalise adder result (right 1 on carry, else left by lzd)
// DONE     | one-cycle completion pulse with zero status
module fpu_shift_sequencer
    import fpu_shift_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 5,
    parameter int EW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [EW-1:0]  exp_diff_i,
    input  logic           add_done_i,
    input  logic           add_ovf_i,
    input  logic [EWR:0]   lzd_count_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           zero_o,
    output logic           bs_load_o,
    output logic [EWR-1:0] bs_shift_value_o,
    output logic           bs_left_right_o,
    output logic           bs_bit_shift_o,
    output logic           bs_data_sel_o
);

    localparam logic [EWR:0] SWR_W = (EWR+1)'(SWR);

    state_t         state;
    state_t         state_next;
    logic [EW-1:0]  diff_q;
    logic           ovf_q;
    logic [EWR:0]   lzd_q;
    logic [EWR-1:0] align_amount;
    logic           result_zero;

    shift_amount_sat #(
        .EW  (EW),
        .EWR (EWR)
    ) u_sat (
        .diff   (diff_q),
        .amount (align_amount)
    );

    // Carry-out takes priority: a carried sum is never zero.
    assign result_zero = !ovf_q && (lzd_q >= SWR_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            diff_q <= '0;
            ovf_q  <= 1'b0;
            lzd_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start_i) begin
                diff_q <= exp_diff_i;
            end
            if (state == ST_ADD_WAIT && add_done_i) begin
                ovf_q <= add_ovf_i;
                lzd_q <= lzd_count_i;
            end
        end
    end

    always_comb begin
        state_next       = state;
        done_o           = 1'b0;
        zero_o           = 1'b0;
        bs_load_o        = 1'b0;
        bs_shift_value_o = '0;
        bs_left_right_o  = DIR_RIGHT;
        bs_data_sel_o    = SEL_OPERAND;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                bs_load_o        = 1'b1;
                bs_shift_value_o = align_amount;
                bs_left_right_o  = DIR_RIGHT;
                bs_data_sel_o    = SEL_OPERAND;
                state_next       = ST_ADD_WAIT;
            end
            ST_ADD_WAIT: begin
                if (add_done_i) begin
                    state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                bs_load_o     = 1'b1;
                bs_data_sel_o = SEL_RESULT;
                if (ovf_q) begin
                    bs_shift_value_o = EWR'(1);
                    bs_left_right_o  = DIR_RIGHT;
                end else if (result_zero) begin
                    bs_shift_value_o = '0;
                    bs_left_right_o  = DIR_LEFT;
                end else begin
                    bs_shift_value_o = lzd_q[EWR-1:0];
                    bs_left_right_o  = DIR_LEFT;
                end
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                zero_o     = result_zero;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o         = (state != ST_IDLE);
    assign bs_bit_shift_o = 1'b0;

endmodule

// File: doc/fpu_shift_sequencer.md
# fpu_shift_sequencer

Controller that time-shares the single registered barrel shifter in the arch2 FP add/sub datapath between two uses: right-shift alignment of the smaller operand and left-shift normalisation of the adder result. It captures the exponent difference on start, drives the shifter's load, amount, direction and fill-bit controls plus the shifter's input-data select, waits for the adder, then issues the normalisation shift. It reports completion and result status to the FPU top-level FSM.

## Interface
Parameters:
- SWR, 26, significand working width (shifter width)
- EWR, 5, shift-amount width of the shifter
- EW, 8, exponent width (width of the exponent difference)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  begin one operation; sampled only in IDLE
- exp_diff_i  in  EW  unsigned exponent difference |Ea-Eb|
- add_done_i  in  1  adder result valid in the datapath (level)
- add_ovf_i  in  1  adder carry-out; sampled with add_done_i
- lzd_count_i  in  EWR+1  leading-zero count of the adder result; sampled with add_done_i
- busy_o  out  1  high from start acceptance until done_o
- done_o  out  1  one-cycle completion pulse
- zero_o  out  1  result significand zero; valid with done_o
- bs_load_o  out  1  shifter output-register load
- bs_shift_value_o  out  EWR  shifter amount
- bs_left_right_o  out  1  1 = left shift, 0 = right shift
- bs_bit_shift_o  out  1  fill bit (always 0)
- bs_data_sel_o  out  1  shifter input select: 0 = smaller operand, 1 = adder result

## Operation
- States: IDLE, ALIGN, ADD_WAIT, NORM, DONE.
- IDLE: all bs_* outputs are 0. When start_i=1, register exp_diff_i and go to ALIGN. start_i outside IDLE is ignored.
- ALIGN, 1 cycle:
  - bs_load_o=1, bs_data_sel_o=0, bs_left_right_o=0.
  - bs_shift_value_o = min(captured diff, 2^EWR-1). The saturation guarantees full zero-out whenever diff >= SWR.
  - Next state ADD_WAIT.
- ADD_WAIT: bs_load_o=0. Hold until add_done_i=1, then capture add_ovf_i and lzd_count_i and go to NORM.
- NORM, 1 cycle: bs_load_o=1, bs_data_sel_o=1. The shift depends on the captured values, checked in this priority order:
  - add_ovf=1: right shift by 1. zero flag=0.
  - lzd_count >= SWR: result is zero. Amount 0, direction left, zero flag=1.
  - otherwise: left shift by lzd_count[EWR-1:0]. zero flag=0.
- DONE, 1 cycle: done_o=1, zero_o=zero flag, bs_load_o=0. Next state IDLE.
- busy_o = (state != IDLE).
- bs_bit_shift_o is constant 0.
- Reset (at any time, including mid-operation) returns the block to IDLE. All outputs and captured registers go to 0. The shifter register contents are not defined by this block.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Cycle s: start_i sampled. s+1: ALIGN. s+2 onwards: ADD_WAIT. If add_done_i is high in cycle a, NORM is a+1 and DONE is a+2.
- Minimum latency start to done_o: 4 cycles, when add_done_i is already high in s+2.
- The shifter output register is valid one cycle after each bs_load_o cycle:
  - aligned operand valid in s+2;
  - normalised result valid in the DONE cycle.
- A new start_i is accepted in the cycle after DONE at the earliest. Back-to-back throughput is 1 operation per 5 cycles minimum.
- Shift amount edge cases:
  - exp_diff_i=0: ALIGN still occurs, with amount 0.
  - exp_diff_i=255: amount 31.

## Structure
- Shared package fpu_shift_pkg holds:
  - state enum;
  - constants ST_IDLE..ST_DONE;
  - DIR_LEFT=1 and DIR_RIGHT=0;
  - SEL_OPERAND=0 and SEL_RESULT=1.
- Sub-module shift_amount_sat (EW to EWR saturating narrower) is instantiated once, on the captured diff.
- The FSM and output registers stay in the top module.

## Test plan
- Reset mid-ADD_WAIT: assert rst while in ADD_WAIT -> all outputs 0 immediately, busy_o=0. A following start_i runs normally.
- Basic operation: start_i with exp_diff_i=3, add_done_i=1 in s+2 with lzd_count_i=2 -> ALIGN amount 3 right; NORM amount 2 left with data_sel=1; done_o at s+4 with zero_o=0.
- Saturation: exp_diff_i=40 -> ALIGN amount 31 right.
- Overflow and stall: add_done_i held low for 6 cycles, then add_ovf_i=1 with lzd_count_i=0 -> bs_load_o=0 throughout the stall; NORM is a right shift by 1; done_o=1 with zero_o=0.
- Zero result: lzd_count_i=26 with add_ovf_i=0 -> NORM amount 0; done_o with zero_o=1.
- Ignored start: start_i pulsed during ALIGN and during ADD_WAIT -> captured diff unchanged, no second operation. Back-to-back start_i in the cycle after DONE is accepted.
